// File: rtl/vis_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vis_pkg
// Brief    : Shared types for the waveform frame-capture block.
// Revision : 1.0
// ============================================================================
package vis_pkg;

    typedef logic signed [15:0] audio_t;
    typedef logic        [9:0]  coord_t;

    typedef enum logic [1:0] {
        ST_ARM     = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } cap_state_t;

    localparam int unsigned c_WORD_W = 32;

    // One RAM word carries the left sample in the upper half.
    function automatic logic [c_WORD_W-1:0] pack_lr(input audio_t l, input audio_t r);
        return {l, r};
    endfunction

endpackage
`default_nettype wire

// File: rtl/wave_frame_capture_if.sv
`default_nettype none
// ============================================================================
// Module   : wave_frame_capture_if
// Brief    : Sample input, display read port and status bundle of the capture.
// Revision : 1.0
// ============================================================================
interface wave_frame_capture_if;
    import vis_pkg::*;

    audio_t iSMP_L;
    audio_t iSMP_R;
    logic   iSMP_STB;
    logic   iVS;
    logic   iLOCK;
    logic   iTRIG_EN;
    coord_t iRD_X;
    audio_t oRD_L;
    audio_t oRD_R;
    logic   oFRAME_RDY;
    logic   oMISS;
    logic   oTRIG_TO;

    modport master (
        output iSMP_L, iSMP_R, iSMP_STB, iVS, iLOCK, iTRIG_EN, iRD_X,
        input  oRD_L, oRD_R, oFRAME_RDY, oMISS, oTRIG_TO
    );

    modport slave (
        input  iSMP_L, iSMP_R, iSMP_STB, iVS, iLOCK, iTRIG_EN, iRD_X,
        output oRD_L, oRD_R, oFRAME_RDY, oMISS, oTRIG_TO
    );

endinterface
`default_nettype wire

// File: rtl/vis_capture_ram.sv
`default_nettype none
// ============================================================================
// Module   : vis_capture_ram
// Brief    : Two-bank simple dual-port RAM; bank bit is the address MSB.
// Revision : 1.0
// ============================================================================
module vis_capture_ram
    import vis_pkg::*;
#(
    parameter int AW = 10
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    input  wire logic                i_we,
    input  wire logic [AW:0]         i_waddr,
    input  wire logic [c_WORD_W-1:0] i_wdata,
    input  wire logic [AW:0]         i_raddr,
    input  wire logic                i_rd_zero,
    output logic      [c_WORD_W-1:0] o_rdata
);

    logic [c_WORD_W-1:0] r_mem [0:(2**(AW+1))-1];
    logic [c_WORD_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Storage is never cleared; only the read register returns to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_rd_zero) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/wave_frame_capture.sv
`default_nettype none
// ============================================================================
// Module   : wave_frame_capture
// Brief    : Triggered, decimated audio frame capture into a ping-pong buffer.
// Revision : 1.0
// ============================================================================
module wave_frame_capture
    import vis_pkg::*;
#(
    parameter int DEPTH        = 640,
    parameter int DECIM        = 1,
    parameter int TRIG_TIMEOUT = 2048
) (
    input  wire logic          iCLK_50,
    input  wire logic          iRST_N,
    wave_frame_capture_if.slave bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = (TRIG_TIMEOUT > 1) ? $clog2(TRIG_TIMEOUT) : 1;

    localparam logic [AW-1:0] c_LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [3:0]    c_DEC_LAST  = 4'(DECIM - 1);
    localparam logic [TW-1:0] c_TO_LAST   = TW'(TRIG_TIMEOUT - 1);

    cap_state_t          r_state;
    cap_state_t          w_state_nxt;
    logic [AW-1:0]       r_waddr;
    logic [AW-1:0]       w_waddr_nxt;
    logic [AW-1:0]       w_wr_addr;
    logic [3:0]          r_dec_cnt;
    logic [3:0]          w_dec_nxt;
    logic [TW-1:0]       r_to_cnt;
    logic [TW-1:0]       w_to_nxt;
    logic                r_trig_to;
    logic                w_trig_to_nxt;
    logic                r_bank;
    logic                r_prev_neg;
    logic                r_vs_prev;
    logic                r_frame_rdy;
    logic                r_miss;
    logic                w_we;
    logic                w_swap;
    logic                w_miss;
    logic                w_vs_edge;
    logic                w_trig;
    logic                w_rd_oob;
    logic [c_WORD_W-1:0] w_rdata;

    assign w_vs_edge = bus.iVS & ~r_vs_prev;
    assign w_trig    = bus.iTRIG_EN ? (r_prev_neg & ~bus.iSMP_L[15]) : 1'b1;
    assign w_rd_oob  = ({22'd0, bus.iRD_X} >= 32'(DEPTH));

    always_ff @(posedge iCLK_50 or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state     <= ST_ARM;
            r_waddr     <= '0;
            r_dec_cnt   <= '0;
            r_to_cnt    <= '0;
            r_trig_to   <= 1'b0;
            r_bank      <= 1'b0;
            r_prev_neg  <= 1'b0;
            r_vs_prev   <= 1'b0;
            r_frame_rdy <= 1'b0;
            r_miss      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_waddr     <= w_waddr_nxt;
            r_dec_cnt   <= w_dec_nxt;
            r_to_cnt    <= w_to_nxt;
            r_trig_to   <= w_trig_to_nxt;
            r_vs_prev   <= bus.iVS;
            r_frame_rdy <= w_swap;
            r_miss      <= w_miss;
            if (w_swap) begin
                r_bank <= ~r_bank;
            end
            if (bus.iSMP_STB) begin
                r_prev_neg <= bus.iSMP_L[15];
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_waddr_nxt   = r_waddr;
        w_wr_addr     = r_waddr;
        w_dec_nxt     = r_dec_cnt;
        w_to_nxt      = r_to_cnt;
        w_trig_to_nxt = r_trig_to;
        w_we          = 1'b0;
        w_swap        = 1'b0;
        w_miss        = 1'b0;

        case (r_state)
            ST_ARM: begin
                w_miss = w_vs_edge;
                if (bus.iSMP_STB) begin
                    // A genuine trigger wins over a timeout landing on the same strobe.
                    if (w_trig || (r_to_cnt == c_TO_LAST)) begin
                        w_we          = 1'b1;
                        w_wr_addr     = '0;
                        w_trig_to_nxt = ~w_trig;
                        w_to_nxt      = '0;
                        w_dec_nxt     = '0;
                        if (c_LAST_ADDR == '0) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_waddr_nxt = AW'(1);
                            w_state_nxt = ST_CAPTURE;
                        end
                    end else begin
                        w_to_nxt = r_to_cnt + 1'b1;
                    end
                end
            end

            ST_CAPTURE: begin
                w_miss = w_vs_edge;
                if (bus.iSMP_STB) begin
                    if (r_dec_cnt == c_DEC_LAST) begin
                        w_dec_nxt = '0;
                        w_we      = 1'b1;
                        if (r_waddr == c_LAST_ADDR) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_waddr_nxt = r_waddr + 1'b1;
                        end
                    end else begin
                        w_dec_nxt = r_dec_cnt + 1'b1;
                    end
                end
            end

            ST_DONE: begin
                if (w_vs_edge && !bus.iLOCK) begin
                    w_swap      = 1'b1;
                    w_state_nxt = ST_ARM;
                end
            end

            default: begin
                w_state_nxt = ST_ARM;
            end
        endcase
    end

    // Capture writes bank r_bank while the display reads the other one.
    vis_capture_ram #(
        .AW (AW)
    ) u_ram (
        .clk       (iCLK_50),
        .rst_n     (iRST_N),
        .i_we      (w_we),
        .i_waddr   ({r_bank, w_wr_addr}),
        .i_wdata   (pack_lr(bus.iSMP_L, bus.iSMP_R)),
        .i_raddr   ({~r_bank, bus.iRD_X[AW-1:0]}),
        .i_rd_zero (w_rd_oob),
        .o_rdata   (w_rdata)
    );

    assign bus.oRD_L      = w_rdata[31:16];
    assign bus.oRD_R      = w_rdata[15:0];
    assign bus.oFRAME_RDY = r_frame_rdy;
    assign bus.oMISS      = r_miss;
    assign bus.oTRIG_TO   = r_trig_to;

endmodule
`default_nettype wire

// File: tb/tb_wave_frame_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_wave_frame_capture
// Brief    : Self-checking bench for wave_frame_capture (DECIM=1 and DECIM=4).
// Revision : 1.0
// ============================================================================
module tb_wave_frame_capture;

    localparam int DEPTH_A = 640;
    localparam int DECIM_A = 1;
    localparam int TO_A    = 2048;

    typedef struct {
        int x;
        int exp_l;
        int exp_r;
    } rd_vec_t;

    logic clk;
    logic rst_n_a;
    logic rst_n_b;

    wave_frame_capture_if bus_a ();
    wave_frame_capture_if bus_b ();

    wave_frame_capture #(.DEPTH(DEPTH_A), .DECIM(DECIM_A), .TRIG_TIMEOUT(TO_A)) dut_a (
        .iCLK_50 (clk),
        .iRST_N  (rst_n_a),
        .bus     (bus_a.slave)
    );

    wave_frame_capture #(.DEPTH(640), .DECIM(4), .TRIG_TIMEOUT(2048)) dut_b (
        .iCLK_50 (clk),
        .iRST_N  (rst_n_b),
        .bus     (bus_b.slave)
    );

    int n_checks = 0;
    int n_errors = 0;
    int last_l;
    bit cur_to;
    int pend_l [DEPTH_A];
    int pend_r [DEPTH_A];
    int disp_l [DEPTH_A];
    int disp_r [DEPTH_A];

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #4000000;
        $display("FAIL watchdog: got time limit, expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic rd_check_a(input string nm, input int x, input int el, input int er);
        bus_a.iRD_X = 10'(x);
        tick();
        check({nm, "_L"}, {16'd0, bus_a.oRD_L}, {16'd0, 16'(el)});
        check({nm, "_R"}, {16'd0, bus_a.oRD_R}, {16'd0, 16'(er)});
    endtask

    // Frame model: collect strobed samples from ARM entry, locate the trigger,
    // then pick every DECIM-th sample after it until DEPTH are gathered.
    task automatic run_frame(input int mode, input bit ten, input int gap_max, input int miss_at);
        int ql[$];
        int qr[$];
        int t;
        bit to;
        int prev;
        int vl;
        int vr;
        bit done;
        t    = -1;
        to   = 1'b0;
        prev = last_l;
        done = 1'b0;
        bus_a.iTRIG_EN = ten;
        for (int i = 0; !done && i < 20000; i++) begin
            case (mode)
                0:       begin vl = i; vr = 1000 - i; end
                1:       begin vl = int'($urandom_range(0, 4000)) - 2000;
                               vr = int'($urandom_range(0, 4000)) - 2000; end
                2:       begin vl = $rtoi(1000.0 * $sin(6.283185307179586 * real'(i + 16) / 64.0));
                               vr = -vl; end
                default: begin vl = 100; vr = 100; end
            endcase
            ql.push_back(vl);
            qr.push_back(vr);
            bus_a.iSMP_L   = 16'(vl);
            bus_a.iSMP_R   = 16'(vr);
            bus_a.iSMP_STB = 1'b1;
            if (i == miss_at) bus_a.iVS = 1'b1;
            tick();
            bus_a.iSMP_STB = 1'b0;
            if (t < 0) begin
                if (!ten || (prev < 0 && vl >= 0)) begin
                    t  = i;
                    to = 1'b0;
                end else if (i == TO_A - 1) begin
                    t  = i;
                    to = 1'b1;
                end
                if (t >= 0) check("trig_to_start", {31'd0, bus_a.oTRIG_TO}, {31'd0, to});
                else        check("trig_to_hold",  {31'd0, bus_a.oTRIG_TO}, {31'd0, cur_to});
            end
            prev = vl;
            if (i == miss_at) begin
                check("miss_pulse", {31'd0, bus_a.oMISS}, 32'd1);
                check("miss_no_rdy", {31'd0, bus_a.oFRAME_RDY}, 32'd0);
                bus_a.iVS = 1'b0;
            end
            if (t >= 0 && i == t + (DEPTH_A - 1) * DECIM_A) done = 1'b1;
            repeat ($urandom_range(0, gap_max)) tick();
        end
        last_l = prev;
        check("frame_complete", {31'd0, done}, 32'd1);
        if (done) begin
            cur_to = to;
            for (int k = 0; k < DEPTH_A; k++) begin
                pend_l[k] = ql[t + k * DECIM_A];
                pend_r[k] = qr[t + k * DECIM_A];
            end
        end
    endtask

    task automatic vs_edge_a(input bit exp_rdy);
        tick();
        bus_a.iVS = 1'b1;
        tick();
        check("frame_rdy", {31'd0, bus_a.oFRAME_RDY}, {31'd0, exp_rdy});
        check("no_miss_in_done", {31'd0, bus_a.oMISS}, 32'd0);
        tick();
        check("frame_rdy_1cyc", {31'd0, bus_a.oFRAME_RDY}, 32'd0);
        bus_a.iVS = 1'b0;
        tick();
        if (exp_rdy) begin
            disp_l = pend_l;
            disp_r = pend_r;
        end
    endtask

    task automatic check_reset_a();
        check("rst_rd_l",  {16'd0, bus_a.oRD_L}, 32'd0);
        check("rst_rd_r",  {16'd0, bus_a.oRD_R}, 32'd0);
        check("rst_rdy",   {31'd0, bus_a.oFRAME_RDY}, 32'd0);
        check("rst_miss",  {31'd0, bus_a.oMISS}, 32'd0);
        check("rst_trigto", {31'd0, bus_a.oTRIG_TO}, 32'd0);
    endtask

    task automatic strobe_b(input int v);
        bus_b.iSMP_L   = 16'(v);
        bus_b.iSMP_R   = 16'(v);
        bus_b.iSMP_STB = 1'b1;
        tick();
        bus_b.iSMP_STB = 1'b0;
    endtask

    initial begin
        rd_vec_t tbl[7];
        int x;
        tbl[0] = '{x: 0,    exp_l: 0,   exp_r: 1000};
        tbl[1] = '{x: 5,    exp_l: 5,   exp_r: 995};
        tbl[2] = '{x: 1,    exp_l: 1,   exp_r: 999};
        tbl[3] = '{x: 320,  exp_l: 320, exp_r: 680};
        tbl[4] = '{x: 639,  exp_l: 639, exp_r: 361};
        tbl[5] = '{x: 640,  exp_l: 0,   exp_r: 0};
        tbl[6] = '{x: 1023, exp_l: 0,   exp_r: 0};

        {bus_a.iSMP_L, bus_a.iSMP_R, bus_a.iSMP_STB, bus_a.iVS} = '0;
        {bus_a.iLOCK, bus_a.iTRIG_EN, bus_a.iRD_X} = '0;
        {bus_b.iSMP_L, bus_b.iSMP_R, bus_b.iSMP_STB, bus_b.iVS} = '0;
        {bus_b.iLOCK, bus_b.iTRIG_EN, bus_b.iRD_X} = '0;
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        last_l  = 0;
        cur_to  = 1'b0;
        repeat (3) tick();
        check_reset_a();
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        tick();

        // Free-running ramp with an early frame edge, then swap and table reads.
        run_frame(0, 1'b0, 1, 300);
        vs_edge_a(1'b1);
        check("ramp_trig_to", {31'd0, bus_a.oTRIG_TO}, 32'd0);
        for (int i = 0; i < 7; i++) begin
            rd_check_a("tbl_rd", tbl[i].x, tbl[i].exp_l, tbl[i].exp_r);
        end

        // Locked display survives three frame edges.
        run_frame(1, 1'b0, 1, -1);
        bus_a.iLOCK = 1'b1;
        for (int e = 0; e < 3; e++) begin
            vs_edge_a(1'b0);
            rd_check_a("lock_hold", 5, 5, 995);
        end
        bus_a.iLOCK = 1'b0;
        vs_edge_a(1'b1);
        rd_check_a("unlock_rd0", 0, disp_l[0], disp_r[0]);
        for (int i = 0; i < 6; i++) begin
            x = int'($urandom_range(0, DEPTH_A - 1));
            rd_check_a("unlock_rd", x, disp_l[x], disp_r[x]);
        end

        // Rising zero-crossing trigger on a sine.
        run_frame(2, 1'b1, 0, -1);
        vs_edge_a(1'b1);
        check("sine_trig_to", {31'd0, bus_a.oTRIG_TO}, 32'd0);
        rd_check_a("sine_rd0", 0, disp_l[0], disp_r[0]);
        for (int i = 0; i < 6; i++) begin
            x = int'($urandom_range(1, DEPTH_A - 1));
            rd_check_a("sine_rd", x, disp_l[x], disp_r[x]);
        end

        // Constant positive input after reset never crosses: capture by timeout.
        tick();
        rst_n_a = 1'b0;
        repeat (2) tick();
        check_reset_a();
        rst_n_a = 1'b1;
        last_l  = 0;
        cur_to  = 1'b0;
        tick();
        run_frame(3, 1'b1, 0, -1);
        vs_edge_a(1'b1);
        check("timeout_level", {31'd0, bus_a.oTRIG_TO}, 32'd1);
        for (int k = 0; k < DEPTH_A; k++) begin
            rd_check_a("timeout_rd", k, 100, 100);
        end

        // Random frames, random trigger mode and strobe spacing.
        for (int f = 0; f < 3; f++) begin
            run_frame(1, 1'($urandom_range(0, 1)), 2, -1);
            vs_edge_a(1'b1);
            rd_check_a("rand_rd0", 0, disp_l[0], disp_r[0]);
            rd_check_a("rand_rd_last", DEPTH_A - 1, disp_l[DEPTH_A - 1], disp_r[DEPTH_A - 1]);
            for (int i = 0; i < 4; i++) begin
                x = int'($urandom_range(0, DEPTH_A - 1));
                rd_check_a("rand_rd", x, disp_l[x], disp_r[x]);
            end
        end

        // DECIM=4: reset in the middle of a capture, then a clean frame.
        bus_b.iTRIG_EN = 1'b0;
        for (int k = 0; k < 800; k++) strobe_b(k);
        bus_b.iVS = 1'b1;
        strobe_b(800);
        check("b_miss_pre_rst", {31'd0, bus_b.oMISS}, 32'd1);
        bus_b.iVS = 1'b0;
        #3;
        rst_n_b = 1'b0;
        #1;
        check("b_rst_miss",   {31'd0, bus_b.oMISS}, 32'd0);
        check("b_rst_rdy",    {31'd0, bus_b.oFRAME_RDY}, 32'd0);
        check("b_rst_trigto", {31'd0, bus_b.oTRIG_TO}, 32'd0);
        check("b_rst_rd_l",   {16'd0, bus_b.oRD_L}, 32'd0);
        check("b_rst_rd_r",   {16'd0, bus_b.oRD_R}, 32'd0);
        repeat (2) tick();
        rst_n_b = 1'b1;
        tick();
        bus_b.iVS = 1'b1;
        tick();
        check("b_arm_miss", {31'd0, bus_b.oMISS}, 32'd1);
        check("b_arm_no_rdy", {31'd0, bus_b.oFRAME_RDY}, 32'd0);
        bus_b.iVS = 1'b0;
        tick();
        for (int k = 0; k <= 639 * 4; k++) strobe_b(k);
        tick();
        bus_b.iVS = 1'b1;
        tick();
        check("b_frame_rdy", {31'd0, bus_b.oFRAME_RDY}, 32'd1);
        bus_b.iVS = 1'b0;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: x = 0;
                1: x = 1;
                2: x = 2;
                3: x = 100;
                4: x = 639;
                default: x = 640;
            endcase
            bus_b.iRD_X = 10'(x);
            tick();
            check("b_decim_rd", {16'd0, bus_b.oRD_L}, (x < 640) ? 32'(4 * x) : 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
